// File: rtl/tx_regfile_stream_if.sv
// Byte-stream link between the register-file dumper and its host.
// Carries the snapshot request/abort handshake, the flattened register
// array and the uart_tx-style start/ready byte port.
interface tx_regfile_stream_if #(
    parameter int NUM_WORDS  = 32,
    parameter int WORD_BYTES = 4
);
    logic                                do_write;
    logic                                abort;
    logic [NUM_WORDS*WORD_BYTES*8-1:0]   reg_file;
    logic                                ready;
    logic                                done;
    logic [7:0]                          tx_data;
    logic                                tx_start;
    logic                                tx_ready;

    // Host side: requests dumps, owns the register tap and the uart idle flag
    modport master (
        output do_write,
        output abort,
        output reg_file,
        output tx_ready,
        input  ready,
        input  done,
        input  tx_data,
        input  tx_start
    );

    // Dumper side: consumes requests and drives bytes towards the uart
    modport slave (
        input  do_write,
        input  abort,
        input  reg_file,
        input  tx_ready,
        output ready,
        output done,
        output tx_data,
        output tx_start
    );
endinterface

// File: rtl/tx_regfile_stream.sv
// Register-file dumper: snapshots a NUM_WORDS x WORD_BYTES array on request
// and streams it byte by byte into a start/ready uart port, optionally
// framed by a header byte in front and an XOR checksum behind the payload.
module tx_regfile_stream #(
    parameter int         NUM_WORDS   = 32,
    parameter int         WORD_BYTES  = 4,
    parameter int         BIG_ENDIAN  = 0,
    parameter int         HEADER_EN   = 0,
    parameter logic [7:0] HEADER_BYTE = 8'hA5,
    parameter int         CHECKSUM_EN = 0
) (
    input logic                clk12,
    input logic                rst,
    tx_regfile_stream_if.slave bus
);

    localparam int NUM_BYTES = NUM_WORDS * WORD_BYTES;
    localparam int SNAP_W    = NUM_BYTES * 8;
    localparam int HDR       = (HEADER_EN != 0) ? 1 : 0;
    localparam int CSUM      = (CHECKSUM_EN != 0) ? 1 : 0;
    localparam int FRAME_LEN = NUM_BYTES + HDR + CSUM;
    localparam int IDX_W     = $clog2(NUM_BYTES + 2);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    state_t              state_q,    state_d;
    logic [SNAP_W-1:0]   snap_q,     snap_d;
    logic [IDX_W-1:0]    index_q,    index_d;
    logic [7:0]          checksum_q, checksum_d;
    logic [7:0]          tx_data_q,  tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                ready_q,    ready_d;
    logic                done_q,     done_d;

    int                  next_pos;
    int                  next_k;
    logic                next_is_payload;
    logic [7:0]          next_byte;
    logic [7:0]          first_byte;

    // Payload byte k lives in word k/WORD_BYTES; the lane inside the word is
    // mirrored for MS-first order. Out-of-range k is clamped so the mux never
    // reads past the array while the checksum slot is being selected.
    function automatic logic [7:0] payload_byte(input logic [SNAP_W-1:0] src,
                                                input int k);
        int kk;
        int word_idx;
        int lane;
        kk = k;
        if (kk >= NUM_BYTES) kk = NUM_BYTES - 1;
        if (kk < 0)          kk = 0;
        word_idx = kk / WORD_BYTES;
        lane     = kk % WORD_BYTES;
        if (BIG_ENDIAN != 0) lane = WORD_BYTES - 1 - lane;
        return src[(word_idx * WORD_BYTES + lane) * 8 +: 8];
    endfunction

    // Work out which byte follows the one currently held in tx_data: a
    // payload byte from the snapshot, or the accumulated checksum at the end.
    always_comb begin
        next_pos        = int'(index_q) + 1;
        next_k          = next_pos - HDR;
        next_is_payload = (next_k >= 0) && (next_k < NUM_BYTES);
        if (next_is_payload) begin
            next_byte = payload_byte(snap_q, next_k);
        end else begin
            next_byte = checksum_q;
        end
        if (HDR != 0) begin
            first_byte = HEADER_BYTE;
        end else begin
            first_byte = payload_byte(bus.reg_file, 0);
        end
    end

    // Frame sequencer: request a byte, wait for the uart to take it, wait for
    // it to finish, then either load the next byte or close the frame.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        index_d    = index_q;
        checksum_d = checksum_q;
        tx_data_d  = tx_data_q;
        tx_start_d = tx_start_q;
        ready_d    = ready_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d    = 1'b1;
                tx_start_d = 1'b0;
                if (bus.do_write) begin
                    snap_d     = bus.reg_file;
                    index_d    = '0;
                    tx_data_d  = first_byte;
                    checksum_d = (HDR != 0) ? 8'h00 : first_byte;
                    tx_start_d = 1'b1;
                    ready_d    = 1'b0;
                    state_d    = ST_START;
                end
            end

            ST_START: begin
                if (bus.abort) begin
                    tx_start_d = 1'b0;
                    ready_d    = 1'b1;
                    state_d    = ST_IDLE;
                end else if (!bus.tx_ready) begin
                    tx_start_d = 1'b0;
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (bus.abort) begin
                    state_d = ST_DRAIN;
                end else if (bus.tx_ready) begin
                    if (index_q == LAST_IDX) begin
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        index_d    = index_q + IDX_W'(1);
                        tx_data_d  = next_byte;
                        if (next_is_payload) begin
                            checksum_d = checksum_q ^ next_byte;
                        end
                        tx_start_d = 1'b1;
                        state_d    = ST_START;
                    end
                end
            end

            ST_DRAIN: begin
                if (bus.tx_ready) begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                ready_d    = 1'b1;
                tx_start_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            snap_q     <= '0;
            index_q    <= '0;
            checksum_q <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            index_q    <= index_d;
            checksum_q <= checksum_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;

endmodule

// File: tb/tb_tx_regfile_stream.sv
// Bench for tx_regfile_stream: three 2x2-byte instances (LS-first, MS-first,
// header+checksum framed) each hooked to a simple uart model, with a shared
// scoreboard of expected bytes checked as each byte request appears.
module tb_tx_regfile_stream;

    typedef struct packed {
        logic [1:0] inst;
        logic [7:0] val;
    } exp_t;

    logic        clk12 = 1'b0;
    logic        rst   = 1'b1;
    logic        abort = 1'b0;
    logic [2:0]  do_write_v = '0;
    logic [31:0] reg_file   = 32'h4433_2211;

    logic [2:0]  tx_ready_v;
    logic [2:0]  tx_start_v;
    logic [2:0]  ready_v;
    logic [2:0]  done_v;
    logic [7:0]  tx_data_v [3];

    exp_t        exp_q [$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          bytes_seen    [3] = '{0, 0, 0};
    int          done_seen     [3] = '{0, 0, 0};
    int          last_rise_cyc [3] = '{0, 0, 0};
    int          ucnt          [3];
    logic [2:0]  tx_start_prev = '0;
    logic [2:0]  tx_ready_prev = '0;
    logic [2:0]  done_prev     = '0;

    logic [7:0]  le_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0]  be_bytes [4] = '{8'h22, 8'h11, 8'h44, 8'h33};
    logic [7:0]  fr_bytes [6] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};

    always #5 clk12 = ~clk12;

    tx_regfile_stream_if #(.NUM_WORDS(2), .WORD_BYTES(2)) if_le ();
    tx_regfile_stream_if #(.NUM_WORDS(2), .WORD_BYTES(2)) if_be ();
    tx_regfile_stream_if #(.NUM_WORDS(2), .WORD_BYTES(2)) if_fr ();

    tx_regfile_stream #(.NUM_WORDS(2), .WORD_BYTES(2), .BIG_ENDIAN(0), .HEADER_EN(0),
                        .HEADER_BYTE(8'hA5), .CHECKSUM_EN(0))
        dut_le (.clk12(clk12), .rst(rst), .bus(if_le));
    tx_regfile_stream #(.NUM_WORDS(2), .WORD_BYTES(2), .BIG_ENDIAN(1), .HEADER_EN(0),
                        .HEADER_BYTE(8'hA5), .CHECKSUM_EN(0))
        dut_be (.clk12(clk12), .rst(rst), .bus(if_be));
    tx_regfile_stream #(.NUM_WORDS(2), .WORD_BYTES(2), .BIG_ENDIAN(0), .HEADER_EN(1),
                        .HEADER_BYTE(8'hA5), .CHECKSUM_EN(1))
        dut_fr (.clk12(clk12), .rst(rst), .bus(if_fr));

    assign if_le.do_write = do_write_v[0];
    assign if_be.do_write = do_write_v[1];
    assign if_fr.do_write = do_write_v[2];
    assign if_le.abort    = abort;
    assign if_be.abort    = abort;
    assign if_fr.abort    = abort;
    assign if_le.reg_file = reg_file;
    assign if_be.reg_file = reg_file;
    assign if_fr.reg_file = reg_file;
    assign if_le.tx_ready = tx_ready_v[0];
    assign if_be.tx_ready = tx_ready_v[1];
    assign if_fr.tx_ready = tx_ready_v[2];

    assign tx_start_v   = {if_fr.tx_start, if_be.tx_start, if_le.tx_start};
    assign ready_v      = {if_fr.ready, if_be.ready, if_le.ready};
    assign done_v       = {if_fr.done, if_be.done, if_le.done};
    assign tx_data_v[0] = if_le.tx_data;
    assign tx_data_v[1] = if_be.tx_data;
    assign tx_data_v[2] = if_fr.tx_data;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk12);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] inst, input logic [7:0] val);
        exp_t e;
        e.inst = inst;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Pulse do_write for one cycle and confirm the one-cycle start latency
    task automatic apply_stimulus(input int inst);
        do_write_v[inst] = 1'b1;
        step();
        check_output($sformatf("start_latency_%0d", inst), 32'(tx_start_v[inst]), 32'd1);
        check_output($sformatf("ready_low_%0d", inst), 32'(ready_v[inst]), 32'd0);
        do_write_v[inst] = 1'b0;
    endtask

    task automatic wait_done(input int inst, input int start_cnt, input string tag);
        int n = 0;
        while (done_seen[inst] == start_cnt && n < 300) begin
            step();
            n++;
        end
        check_output(tag, 32'(done_seen[inst]), 32'(start_cnt + 1));
    endtask

    task automatic wait_uart_idle(input string tag);
        int n = 0;
        while (tx_ready_v !== 3'b111 && n < 50) begin
            step();
            n++;
        end
        check_output(tag, 32'(tx_ready_v), 32'h7);
    endtask

    // Uart model: takes a byte one cycle after tx_start, busy for 10 cycles
    always @(posedge clk12 or posedge rst) begin
        if (rst) begin
            tx_ready_v <= 3'b111;
            for (int i = 0; i < 3; i++) ucnt[i] <= 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (ucnt[i] == 0) begin
                    if (tx_start_v[i] && tx_ready_v[i]) begin
                        tx_ready_v[i] <= 1'b0;
                        ucnt[i]       <= 10;
                    end
                end else begin
                    ucnt[i] <= ucnt[i] - 1;
                    if (ucnt[i] == 1) tx_ready_v[i] <= 1'b1;
                end
            end
        end
    end

    // Monitor: score each new byte request and check done pulse placement
    always @(negedge clk12) begin
        exp_t e;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (tx_ready_v[i] && !tx_ready_prev[i]) last_rise_cyc[i] = cyc;
            if (tx_start_v[i] && !tx_start_prev[i]) begin
                bytes_seen[i]++;
                check_output($sformatf("sb_nonempty_%0d", i), 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_output($sformatf("byte_inst_%0d", i), 32'(i), 32'(e.inst));
                    check_output($sformatf("byte_data_%0d", i), 32'(tx_data_v[i]), 32'(e.val));
                end
            end
            if (done_v[i]) begin
                done_seen[i]++;
                check_output($sformatf("done_latency_%0d", i), 32'(cyc - last_rise_cyc[i]), 32'd1);
                check_output($sformatf("done_width_%0d", i), 32'(done_prev[i]), 32'd0);
            end
        end
        tx_start_prev = tx_start_v;
        tx_ready_prev = tx_ready_v;
        done_prev     = done_v;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int b0;
        int d0;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        check_output("rst_ready", 32'(ready_v), 32'h7);
        check_output("rst_done", 32'(done_v), 32'h0);
        check_output("rst_tx_start", 32'(tx_start_v), 32'h0);
        for (int i = 0; i < 3; i++)
            check_output($sformatf("rst_tx_data_%0d", i), 32'(tx_data_v[i]), 32'h0);
        rst = 1'b0;
        step();

        // LS-first, unframed
        foreach (le_bytes[k]) push_exp(2'd0, le_bytes[k]);
        b0 = bytes_seen[0];
        d0 = done_seen[0];
        apply_stimulus(0);
        wait_done(0, d0, "le_done");
        check_output("le_ready_after", 32'(ready_v[0]), 32'd1);
        check_output("le_len", 32'(bytes_seen[0] - b0), 32'd4);
        check_output("le_sb_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) step();

        // MS-first, unframed
        foreach (be_bytes[k]) push_exp(2'd1, be_bytes[k]);
        b0 = bytes_seen[1];
        d0 = done_seen[1];
        apply_stimulus(1);
        wait_done(1, d0, "be_done");
        check_output("be_len", 32'(bytes_seen[1] - b0), 32'd4);
        repeat (3) step();

        // Header plus checksum
        foreach (fr_bytes[k]) push_exp(2'd2, fr_bytes[k]);
        b0 = bytes_seen[2];
        d0 = done_seen[2];
        apply_stimulus(2);
        wait_done(2, d0, "fr_done");
        check_output("fr_len", 32'(bytes_seen[2] - b0), 32'd6);
        check_output("fr_ready_after", 32'(ready_v[2]), 32'd1);
        repeat (3) step();

        // Snapshot isolation and ignored mid-frame request
        foreach (le_bytes[k]) push_exp(2'd0, le_bytes[k]);
        b0 = bytes_seen[0];
        d0 = done_seen[0];
        apply_stimulus(0);
        step();
        reg_file = 32'h0;
        do_write_v[0] = 1'b1;
        step();
        do_write_v[0] = 1'b0;
        wait_done(0, d0, "snap_done");
        repeat (30) step();
        check_output("snap_len", 32'(bytes_seen[0] - b0), 32'd4);
        check_output("snap_one_frame", 32'(done_seen[0] - d0), 32'd1);
        reg_file = 32'h4433_2211;
        wait_uart_idle("snap_idle");

        // Abort during the second byte's WAIT
        push_exp(2'd0, 8'h11);
        push_exp(2'd0, 8'h22);
        b0 = bytes_seen[0];
        d0 = done_seen[0];
        apply_stimulus(0);
        n = 0;
        while (!(bytes_seen[0] == b0 + 2 && tx_start_v[0] == 1'b0) && n < 100) begin
            step();
            n++;
        end
        check_output("abort_reach_wait2", 32'(bytes_seen[0] - b0), 32'd2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_output("drain_ready_low", 32'(ready_v[0]), 32'd0);
        check_output("drain_uart_busy", 32'(tx_ready_v[0]), 32'd0);
        n = 0;
        while (ready_v[0] == 1'b0 && n < 50) begin
            step();
            n++;
        end
        check_output("drain_ready_back", 32'(ready_v[0]), 32'd1);
        check_output("drain_uart_idle", 32'(tx_ready_v[0]), 32'd1);
        repeat (20) step();
        check_output("abort_no_done", 32'(done_seen[0] - d0), 32'd0);
        check_output("abort_len", 32'(bytes_seen[0] - b0), 32'd2);
        check_output("abort_sb_empty", 32'(exp_q.size()), 32'd0);

        // Abort while in START
        push_exp(2'd0, 8'h11);
        d0 = done_seen[0];
        apply_stimulus(0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_output("start_abort_tx_start", 32'(tx_start_v[0]), 32'd0);
        check_output("start_abort_ready", 32'(ready_v[0]), 32'd1);
        wait_uart_idle("start_abort_idle");
        check_output("start_abort_no_done", 32'(done_seen[0] - d0), 32'd0);

        // Reset in the middle of the third byte, then restart cleanly
        foreach (le_bytes[k]) push_exp(2'd0, le_bytes[k]);
        b0 = bytes_seen[0];
        apply_stimulus(0);
        n = 0;
        while (bytes_seen[0] != b0 + 3 && n < 100) begin
            step();
            n++;
        end
        check_output("rst_reach_byte3", 32'(bytes_seen[0] - b0), 32'd3);
        repeat (3) step();
        rst = 1'b1;
        #1;
        check_output("rst_async_tx_start", 32'(tx_start_v[0]), 32'd0);
        check_output("rst_async_ready", 32'(ready_v[0]), 32'd1);
        step();
        check_output("rst_leftover", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        rst = 1'b0;
        step();
        foreach (le_bytes[k]) push_exp(2'd0, le_bytes[k]);
        b0 = bytes_seen[0];
        d0 = done_seen[0];
        apply_stimulus(0);
        wait_done(0, d0, "restart_done");
        check_output("restart_len", 32'(bytes_seen[0] - b0), 32'd4);

        repeat (5) step();
        check_output("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
